// File: rtl/cv32e40p_xmem_responder_if.sv
// ============================================================================
//  Module      : cv32e40p_x_if_pkg / cv32e40p_xmem_responder_if
//  Description : xmem request/response type and the bundled xmem + OBI data
//                port signals seen by the xmem responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_x_if_pkg;
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;
endpackage

interface cv32e40p_xmem_responder_if;
    logic                              xmem_q_valid_i;
    logic                              xmem_q_ready_o;
    logic [31:0]                       xmem_q_laddr_i;
    logic [31:0]                       xmem_q_wdata_i;
    logic [2:0]                        xmem_q_width_i;
    cv32e40p_x_if_pkg::mem_req_type_e  xmem_q_req_type_i;
    logic                              xmem_q_mode_i;
    logic                              xmem_q_spec_i;
    logic                              xmem_q_endoftransaction_i;
    logic                              xmem_p_valid_o;
    logic                              xmem_p_ready_i;
    logic [31:0]                       xmem_p_rdata_o;
    logic [4:0]                        xmem_p_range_o;
    logic                              xmem_p_status_o;
    logic                              data_req_o;
    logic                              data_gnt_i;
    logic [31:0]                       data_addr_o;
    logic                              data_we_o;
    logic [3:0]                        data_be_o;
    logic [31:0]                       data_wdata_o;
    logic                              data_rvalid_i;
    logic [31:0]                       data_rdata_i;
    logic                              data_err_i;

    // Responder view: slave on xmem, initiator on the OBI data port.
    modport slave (
        input  xmem_q_valid_i, xmem_q_laddr_i, xmem_q_wdata_i, xmem_q_width_i,
               xmem_q_req_type_i, xmem_q_mode_i, xmem_q_spec_i,
               xmem_q_endoftransaction_i, xmem_p_ready_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output xmem_q_ready_o, xmem_p_valid_o, xmem_p_rdata_o, xmem_p_range_o,
               xmem_p_status_o, data_req_o, data_addr_o, data_we_o, data_be_o,
               data_wdata_o
    );

    modport master (
        output xmem_q_valid_i, xmem_q_laddr_i, xmem_q_wdata_i, xmem_q_width_i,
               xmem_q_req_type_i, xmem_q_mode_i, xmem_q_spec_i,
               xmem_q_endoftransaction_i, xmem_p_ready_i,
               data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  xmem_q_ready_o, xmem_p_valid_o, xmem_p_rdata_o, xmem_p_range_o,
               xmem_p_status_o, data_req_o, data_addr_o, data_we_o, data_be_o,
               data_wdata_o
    );
endinterface

`default_nettype wire

// File: rtl/cv32e40p_xmem_responder.sv
// ============================================================================
//  Module      : cv32e40p_xmem_responder
//  Description : Turns each xmem request into one OBI data transaction and
//                returns one xmem response. Optional macro
//                CV32E40P_XMEM_ERR_CHECK_EN enables illegal-request detection
//                and bus-error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_xmem_responder #(
    parameter int unsigned SIGN_EXTEND = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    cv32e40p_xmem_responder_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RSP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  width_q, width_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  range_q, range_d;
    logic        status_q, status_d;

    logic [1:0]  w_width;
    logic [31:0] w_laddr;
    logic        w_illegal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [4:0]  w_range;
    logic [31:0] w_lane;
    logic [31:0] w_rdata_ext;
    logic        w_err;
    logic        w_unused;

    // Request decode: effective width, address and legality.
    always_comb begin
        w_illegal = 1'b0;
        w_laddr   = bus.xmem_q_laddr_i;
        w_width   = (bus.xmem_q_width_i > 3'd2) ? 2'd2 : bus.xmem_q_width_i[1:0];
`ifdef CV32E40P_XMEM_ERR_CHECK_EN
        case (bus.xmem_q_width_i)
            3'd0:    w_illegal = 1'b0;
            3'd1:    w_illegal = bus.xmem_q_laddr_i[0];
            3'd2:    w_illegal = |bus.xmem_q_laddr_i[1:0];
            default: w_illegal = 1'b1;
        endcase
        if ((bus.xmem_q_req_type_i == cv32e40p_x_if_pkg::WRITE) && bus.xmem_q_spec_i) begin
            w_illegal = 1'b1;
        end
`else
        case (w_width)
            2'd1:    w_laddr[0]   = 1'b0;
            2'd2:    w_laddr[1:0] = 2'b00;
            default: w_laddr[1:0] = bus.xmem_q_laddr_i[1:0];
        endcase
`endif
    end

`ifdef CV32E40P_XMEM_ERR_CHECK_EN
    assign w_err = bus.data_err_i;
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        case (w_width)
            2'd0: begin
                w_be    = 4'b0001 << w_laddr[1:0];
                w_wdata = {4{bus.xmem_q_wdata_i[7:0]}};
                w_range = 5'd7;
            end
            2'd1: begin
                w_be    = 4'b0011 << w_laddr[1:0];
                w_wdata = {2{bus.xmem_q_wdata_i[15:0]}};
                w_range = 5'd15;
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = bus.xmem_q_wdata_i;
                w_range = 5'd31;
            end
        endcase
    end

    // Read data is returned LSB-aligned, so shift the addressed lane down.
    assign w_lane = bus.data_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (width_q)
            2'd0:    w_rdata_ext = (SIGN_EXTEND != 0) ? {{24{w_lane[7]}}, w_lane[7:0]}
                                                      : {24'd0, w_lane[7:0]};
            2'd1:    w_rdata_ext = (SIGN_EXTEND != 0) ? {{16{w_lane[15]}}, w_lane[15:0]}
                                                      : {16'd0, w_lane[15:0]};
            default: w_rdata_ext = w_lane;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        off_d    = off_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        range_d  = range_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (bus.xmem_q_valid_i) begin
                    width_d  = w_width;
                    off_d    = w_laddr[1:0];
                    range_d  = w_range;
                    rdata_d  = '0;
                    status_d = 1'b0;
                    if (w_illegal) begin
                        // Rejected without touching the OBI port.
                        status_d = 1'b1;
                        state_d  = RSP;
                    end else begin
                        we_d    = (bus.xmem_q_req_type_i == cv32e40p_x_if_pkg::WRITE);
                        addr_d  = {w_laddr[31:2], 2'b00};
                        be_d    = w_be;
                        wdata_d = w_wdata;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_rvalid_i) begin
                    rdata_d  = we_q ? 32'd0 : w_rdata_ext;
                    status_d = w_err;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (bus.xmem_p_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            width_q  <= 2'd0;
            off_q    <= 2'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            range_q  <= 5'd0;
            status_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            off_q    <= off_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            range_q  <= range_d;
            status_q <= status_d;
        end
    end

    assign bus.xmem_q_ready_o  = (state_q == IDLE);
    assign bus.xmem_p_valid_o  = (state_q == RSP);
    assign bus.xmem_p_rdata_o  = rdata_q;
    assign bus.xmem_p_range_o  = range_q;
    assign bus.xmem_p_status_o = status_q;
    assign bus.data_req_o      = (state_q == REQ);
    assign bus.data_addr_o     = addr_q;
    assign bus.data_we_o       = we_q;
    assign bus.data_be_o       = be_q;
    assign bus.data_wdata_o    = wdata_q;

    assign w_unused = ^{bus.xmem_q_mode_i, bus.xmem_q_endoftransaction_i,
                        bus.xmem_q_spec_i, bus.data_err_i};

endmodule

`default_nettype wire

// File: doc/cv32e40p_xmem_responder.md
Name: cv32e40p_xmem_responder

Overview:
Core-side responder for the xmem channel of the X-interface. It accepts memory requests issued by the accelerator adapter, performs each one as a single OBI data transaction on a dedicated data port, and returns exactly one xmem response per accepted request. Only one transaction is outstanding at a time. The block sits between the core's xmem wires and the data-memory interconnect.

Parameters:
SIGN_EXTEND, 0, 1: byte/half reads sign-extended into p_rdata; 0: zero-extended.

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
xmem_q_valid_i  in  1  request valid
xmem_q_ready_o  out  1  request ready
xmem_q_laddr_i  in  32  byte address
xmem_q_wdata_i  in  32  write data, LSB-aligned
xmem_q_width_i  in  3  0=byte, 1=half, 2=word, others illegal
xmem_q_req_type_i  in  cv32e40p_x_if_pkg::mem_req_type_e  READ or WRITE
xmem_q_mode_i  in  1  carried, unused
xmem_q_spec_i  in  1  speculative request
xmem_q_endoftransaction_i  in  1  carried, unused
xmem_p_valid_o  out  1  response valid
xmem_p_ready_i  in  1  response ready
xmem_p_rdata_o  out  32  read data, LSB-aligned
xmem_p_range_o  out  5  MSB index of valid data: 7/15/31
xmem_p_status_o  out  1  0=ok, 1=error
data_req_o  out  1  OBI request
data_gnt_i  in  1  OBI grant
data_addr_o  out  32  word-aligned OBI address
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-shifted write data
data_rvalid_i  in  1  OBI response valid
data_rdata_i  in  32  OBI read data
data_err_i  in  1  OBI bus error

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE; xmem_q_ready_o=1; xmem_p_valid_o=0; rdata/range/status=0; data_req_o=0; data_we_o=0; data_be_o=0; data_addr_o=0; data_wdata_o=0.
- FSM has four states: IDLE, REQ, WAIT, RSP.
- IDLE: q_ready=1. On q_valid&&q_ready, latch all request fields.
  - Legal request: go to REQ.
  - Illegal request: go to RSP with status=1.
- REQ: data_req_o=1 with stable addr/we/be/wdata until data_gnt_i. On gnt, go to WAIT. A gnt in the same cycle req first rises is legal.
- WAIT: wait for data_rvalid_i.
  - Reads: rdata = byte/half lane selected by laddr[1:0], then extended per SIGN_EXTEND. Writes: rdata=0.
  - status = data_err_i. Go to RSP.
  - rvalid in the same cycle as gnt is not possible (OBI); ignore rvalid outside WAIT.
- RSP: p_valid=1, all p_* outputs held stable until p_ready. On handshake go to IDLE. q_ready is 0 in REQ/WAIT/RSP, so there is no accept-on-response-cycle bypass.
- Minimum latency: accept at cycle 0, data_req_o at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, p_valid is high at cycle 3.
- Lane rules:
  - data_addr_o = {laddr[31:2],2'b00}.
  - be: byte = 1<<laddr[1:0]; half = 2'b11<<laddr[1:0]; word = 4'hF.
  - wdata replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- range = 7/15/31 for byte/half/word, including error responses; 31 for illegal width.
- Illegal request (under XMEM_ERR_CHECK_EN only): width>2; half with laddr[0]=1; word with laddr[1:0]!=0; WRITE with spec=1. No OBI transaction is issued; p_valid is high the cycle after accept.
- Reset mid-operation: all state is cleared immediately. An OBI transaction in flight is abandoned; any late rvalid arriving in IDLE is ignored.

Optional Feature:
Macro: CV32E40P_XMEM_ERR_CHECK_EN.
- Defined: illegal-request detection active; status = data_err_i or 1 for illegal requests.
- Undefined:
  - No request is illegal. Width>2 is treated as word; the address is forced to natural alignment (low bits cleared per width).
  - Speculative writes are performed.
  - status_o is tied to 0 and data_err_i is ignored.

Test Plan:
- Word read, laddr=0x1000_0004, gnt same cycle, rvalid next with rdata=0xDEADBEEF → data_addr=0x1000_0004, be=4'hF, we=0. p_valid at cycle 3 with rdata=0xDEADBEEF, range=31, status=0.
- Byte read, laddr=0x...03, rdata=0x80112233, SIGN_EXTEND=1 → be=4'b1000, p_rdata=0xFFFFFF80, range=7. With SIGN_EXTEND=0 → p_rdata=0x00000080.
- Half write, laddr=0x...02, wdata=0x0000ABCD, gnt delayed 3 cycles → req/addr/be=4'b1100/wdata=0xABCDABCD stable all 4 cycles. p_valid with rdata=0, range=15.
- p_ready held low 5 cycles → p_* stable, q_ready=0, a new q_valid is not accepted until after the handshake.
- With CV32E40P_XMEM_ERR_CHECK_EN: word read at laddr=0x...02 → no data_req_o, p_valid next cycle, status=1. data_err_i=1 on rvalid → status=1.
- rst_ni asserted during WAIT → outputs at reset values next edge; an rvalid arriving after release is ignored; the next request completes normally.
